// File: rtl/reg_dest_scoreboard_pkg.sv
// Shared constants and types for the destination-register scoreboard.
// Holds the register address width, register count, the x0 address,
// the per-register pending-write counter type and its maximum value.
package reg_dest_scoreboard_pkg;

  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;
  localparam int CNT_W  = 2;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/reg_dest_counter.sv
// Single pending-write counter for one architectural register.
// Counts up on an accepted issue and down on a writeback. It never wraps:
// an increment at CNT_MAX is dropped (the issue handshake already refuses
// it) and a decrement at zero is dropped and reported on underflow.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear, wins over inc/dec
//   inc         accepted issue targeting this register
//   dec         writeback targeting this register
//   cnt         current count
//   nonzero     cnt != 0
//   full        cnt == CNT_MAX
//   underflow   dec requested while cnt == 0 (combinational, masked by clr)
module reg_dest_counter
  import reg_dest_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             full,
  output logic             underflow
);

  logic inc_eff;
  logic dec_eff;

  assign nonzero   = (cnt != '0);
  assign full      = (cnt == CNT_MAX);
  assign inc_eff   = inc && !full;
  assign dec_eff   = dec && nonzero;
  // A flush discards the writeback as well, so it cannot raise underflow.
  assign underflow = dec && !nonzero && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc_eff && !dec_eff) begin
      cnt <= cnt + 1'b1;
    end else if (dec_eff && !inc_eff) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_dest_scoreboard.sv
// Destination-register scoreboard between decode and writeback.
// Decode posts the destination of each issuing instruction, writeback
// retires it, and the two source queries report whether a write to that
// register is still in flight (used to stall decode). x0 is never tracked.
//
// Build option: SCOREBOARD_WB_BYPASS_EN
//   When defined, a source whose only pending write is being written back
//   this very cycle reads as not busy, because the register file forwards
//   the writeback value.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         clear all pending entries (wins over issue/writeback)
//   issue_valid   decode issues an instruction writing issue_addr
//   issue_addr    destination register of the issuing instruction
//   issue_ready   the issue can be accepted this cycle
//   wb_valid      writeback retires a write to wb_addr
//   wb_addr       destination register being written back
//   rs1_addr      source 1 query
//   rs2_addr      source 2 query
//   rs1_busy      rs1 has a pending write
//   rs2_busy      rs2 has a pending write
//   any_pending   at least one register has a pending write
//   wb_underflow  sticky: a writeback arrived with nothing pending
module reg_dest_scoreboard
  import reg_dest_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              any_pending,
  output logic              wb_underflow
);

  cnt_t             cnt_arr  [NREGS];
  logic [NREGS-1:0] nz_vec;
  logic [NREGS-1:0] full_vec;
  logic [NREGS-1:1] inc_vec;
  logic [NREGS-1:1] dec_vec;
  logic [NREGS-1:1] uf_vec;
  logic             issue_fire;

  // x0 has no counter; its slot reads as permanently empty.
  assign cnt_arr[0]  = '0;
  assign nz_vec[0]   = 1'b0;
  assign full_vec[0] = 1'b0;

  assign issue_ready = (issue_addr == REG_ZERO) || !full_vec[issue_addr];
  assign issue_fire  = issue_valid && issue_ready;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    localparam logic [ADDR_W-1:0] R_ADDR = ADDR_W'(r);

    assign inc_vec[r] = issue_fire && (issue_addr == R_ADDR);
    assign dec_vec[r] = wb_valid && (wb_addr == R_ADDR);

    reg_dest_counter u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (flush),
      .inc       (inc_vec[r]),
      .dec       (dec_vec[r]),
      .cnt       (cnt_arr[r]),
      .nonzero   (nz_vec[r]),
      .full      (full_vec[r]),
      .underflow (uf_vec[r])
    );
  end

  assign any_pending = |nz_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_underflow <= 1'b0;
    end else if (|uf_vec) begin
      wb_underflow <= 1'b1;
    end
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  // Last outstanding write retiring now: the value is forwarded, so no stall.
  logic rs1_fwd;
  logic rs2_fwd;

  assign rs1_fwd  = wb_valid && (wb_addr == rs1_addr) && (cnt_arr[rs1_addr] == cnt_t'(1));
  assign rs2_fwd  = wb_valid && (wb_addr == rs2_addr) && (cnt_arr[rs2_addr] == cnt_t'(1));
  assign rs1_busy = (cnt_arr[rs1_addr] != '0) && !rs1_fwd;
  assign rs2_busy = (cnt_arr[rs2_addr] != '0) && !rs2_fwd;
`else
  assign rs1_busy = (cnt_arr[rs1_addr] != '0);
  assign rs2_busy = (cnt_arr[rs2_addr] != '0);
`endif

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Directed self-checking bench for reg_dest_scoreboard.
module tb_reg_dest_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       issue_valid;
  logic [4:0] issue_addr;
  logic       issue_ready;
  logic       wb_valid;
  logic [4:0] wb_addr;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic       rs1_busy;
  logic       rs2_busy;
  logic       any_pending;
  logic       wb_underflow;

  int checks   = 0;
  int failures = 0;

  reg_dest_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .any_pending  (any_pending),
    .wb_underflow (wb_underflow)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 more unit later, well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_addr  = 5'd0;
    wb_valid    = 1'b0;
    wb_addr     = 5'd0;
  endtask

  task automatic issue_one(input logic [4:0] a);
    issue_valid = 1'b1;
    issue_addr  = a;
    tick();
    idle();
    #1;
  endtask

  task automatic wb_one(input logic [4:0] a);
    wb_valid = 1'b1;
    wb_addr  = a;
    tick();
    idle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    #2;
    checks++;
    if (any_pending !== 1'b0 || wb_underflow !== 1'b0 || rs1_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: pend=%b uf=%b busy=%b required 0 0 0", any_pending, wb_underflow, rs1_busy);
    end
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b required 1", issue_ready);
    end
    tick();
    rst_n = 1'b1;
    // Build up state: x5 three times plus an underflow on x1.
    issue_one(5'd5);
    issue_one(5'd5);
    issue_one(5'd5);
    wb_one(5'd1);
    checks++;
    if (rs1_busy !== 1'b1 || wb_underflow !== 1'b1) begin
      failures++;
      $display("FAIL reset_setup: busy=%b uf=%b required 1 1", rs1_busy, wb_underflow);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || any_pending !== 1'b0 || wb_underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: busy=%b pend=%b uf=%b required 0 0 0", rs1_busy, any_pending, wb_underflow);
    end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    issue_one(5'd7);
    rs1_addr = 5'd7;
    rs2_addr = 5'd8;
    #1;
    checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0 || any_pending !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: rs1=%b rs2=%b pend=%b required 1 0 1", rs1_busy, rs2_busy, any_pending);
    end
    wb_one(5'd7);
    checks++;
    if (rs1_busy !== 1'b0 || any_pending !== 1'b0) begin
      failures++;
      $display("FAIL basic_clear: rs1=%b pend=%b required 0 0", rs1_busy, any_pending);
    end
  endtask

  task automatic test_saturate();
    rs1_addr = 5'd3;
    issue_valid = 1'b1;
    issue_addr  = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin
        failures++;
        $display("FAIL sat_ready_%0d: got %b required 1", i, issue_ready);
      end
      tick();
    end
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL sat_ready_full: got %b required 0", issue_ready);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rs1_busy !== 1'b1) begin
      failures++;
      $display("FAIL sat_no_wrap: busy=%b required 1", rs1_busy);
    end
    for (int i = 0; i < 3; i++) begin
      wb_one(5'd3);
      checks++;
      if (rs1_busy !== (i < 2)) begin
        failures++;
        $display("FAIL sat_drain_%0d: busy=%b required %b", i, rs1_busy, (i < 2));
      end
    end
    checks++;
    if (wb_underflow !== 1'b0) begin
      failures++;
      $display("FAIL sat_uf: got %b required 0", wb_underflow);
    end
  endtask

  task automatic test_same_edge();
    rs1_addr = 5'd9;
    rs2_addr = 5'd2;
    issue_one(5'd9);
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    wb_valid    = 1'b1;
    wb_addr     = 5'd9;
    tick();
    idle();
    #1;
    checks++;
    if (rs1_busy !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_busy: got %b required 1", rs1_busy);
    end
    // Issue x0 is a no-op; x9 still pending.
    issue_valid = 1'b1;
    issue_addr  = 5'd0;
    rs2_addr    = 5'd0;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || rs2_busy !== 1'b0) begin
      failures++;
      $display("FAIL x0_query: ready=%b busy=%b required 1 0", issue_ready, rs2_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (any_pending !== 1'b1 || rs2_busy !== 1'b0) begin
      failures++;
      $display("FAIL x0_issue: pend=%b busy=%b required 1 0", any_pending, rs2_busy);
    end
    // Different addresses in the same edge: issue x2, retire the single x9.
    rs2_addr    = 5'd2;
    issue_valid = 1'b1;
    issue_addr  = 5'd2;
    wb_valid    = 1'b1;
    wb_addr     = 5'd9;
    tick();
    idle();
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1) begin
      failures++;
      $display("FAIL indep_edge: rs1=%b rs2=%b required 0 1", rs1_busy, rs2_busy);
    end
    wb_one(5'd2);
    checks++;
    if (any_pending !== 1'b0 || wb_underflow !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_end: pend=%b uf=%b required 0 0", any_pending, wb_underflow);
    end
  endtask

  task automatic test_underflow();
    wb_one(5'd0);
    checks++;
    if (wb_underflow !== 1'b0) begin
      failures++;
      $display("FAIL uf_x0: got %b required 0", wb_underflow);
    end
    wb_one(5'd12);
    checks++;
    if (wb_underflow !== 1'b1) begin
      failures++;
      $display("FAIL uf_set: got %b required 1", wb_underflow);
    end
    rs1_addr = 5'd12;
    issue_one(5'd12);
    wb_one(5'd12);
    checks++;
    if (wb_underflow !== 1'b1 || rs1_busy !== 1'b0) begin
      failures++;
      $display("FAIL uf_sticky: uf=%b busy=%b required 1 0", wb_underflow, rs1_busy);
    end
  endtask

  task automatic test_flush();
    issue_one(5'd4);
    issue_one(5'd6);
    rs1_addr = 5'd4;
    rs2_addr = 5'd6;
    #1;
    checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre: rs1=%b rs2=%b required 1 1", rs1_busy, rs2_busy);
    end
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_addr  = 5'd10;
    tick();
    idle();
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || any_pending !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: rs1=%b rs2=%b pend=%b required 0 0 0", rs1_busy, rs2_busy, any_pending);
    end
    rs1_addr = 5'd10;
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || wb_underflow !== 1'b1) begin
      failures++;
      $display("FAIL flush_x10: busy=%b uf=%b required 0 1", rs1_busy, wb_underflow);
    end
  endtask

  task automatic test_bypass();
    logic exp_busy;
`ifdef SCOREBOARD_WB_BYPASS_EN
    exp_busy = 1'b0;
`else
    exp_busy = 1'b1;
`endif
    issue_one(5'd4);
    rs1_addr = 5'd4;
    wb_valid = 1'b1;
    wb_addr  = 5'd4;
    #1;
    checks++;
    if (rs1_busy !== exp_busy) begin
      failures++;
      $display("FAIL bypass_busy: got %b required %b", rs1_busy, exp_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || any_pending !== 1'b0) begin
      failures++;
      $display("FAIL bypass_after: busy=%b pend=%b required 0 0", rs1_busy, any_pending);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_same_edge();
    test_underflow();
    test_flush();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
